// File: rtl/fetch_pc_unit.sv
// Instruction fetch / PC stage: issues word fetches, buffers up to two returned
// instructions for decode, and applies execute-stage redirects and link writes.
module fetch_pc_unit #(
  parameter int          PC_W     = 20,
  parameter int unsigned LINK_REG = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      pcjumpenable,
  input  logic [8:0]      pcchange,
  input  logic [5:0]      pclocation,
  input  logic [PC_W-1:0] exec_pc,
  output logic [5:0]      jump_reg,
  input  logic [15:0]     jump_reg_data,
  output logic [5:0]      link_wr,
  output logic [15:0]     link_wr_data,
  output logic            link_wr_enable,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] previous_programcounter
);

  localparam logic [2:0] CMD_REL      = 3'd1;
  localparam logic [2:0] CMD_ABS      = 3'd2;
  localparam logic [2:0] CMD_ABS_LINK = 3'd3;
  localparam logic [2:0] CMD_REL_LINK = 3'd4;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [15:0]     instr0_q, instr0_d, instr1_q, instr1_d;
  logic [PC_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]      count_q, count_d;
  logic [1:0]      inflight_q, inflight_d;
  logic [1:0]      drop_q, drop_d;
  logic [PC_W-1:0] reqPc_q [2];
  logic [PC_W-1:0] reqPc_d [2];
  logic            reqWr_q, reqWr_d, reqRd_q, reqRd_d;
  logic            linkEn_q, linkEn_d;
  logic [15:0]     linkData_q, linkData_d;

  logic            grant, retValid, retKeep, pop, redirect, isLink;
  logic [PC_W-1:0] retPc, target, relTarget, absTarget;

  assign imem_req = ~reset & (({1'b0, count_q} + {1'b0, inflight_q}) < 3'd2);
  assign imem_addr = fetch_pc_q;
  assign previous_programcounter = fetch_pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr = instr0_q;
  assign instr_pc = pc0_q;
  assign jump_reg = pclocation;
  assign link_wr = linkEn_q ? 6'(LINK_REG) : 6'd0;
  assign link_wr_data = linkData_q;
  assign link_wr_enable = linkEn_q;

  assign relTarget = exec_pc + {{(PC_W-9){pcchange[8]}}, pcchange};
  assign absTarget = {{(PC_W-16){1'b0}}, jump_reg_data};

  always_comb begin
    grant    = imem_req & imem_gnt;
    // Returns with nothing outstanding (e.g. stale ones after reset) are ignored.
    retValid = imem_rvalid & (inflight_q != 2'd0);
    retKeep  = retValid & (drop_q == 2'd0);
    pop      = instr_valid & instr_ready;
    redirect = (pcjumpenable != 3'd0) && (pcjumpenable <= CMD_REL_LINK);
    isLink   = (pcjumpenable == CMD_ABS_LINK) || (pcjumpenable == CMD_REL_LINK);
    retPc    = reqPc_q[reqRd_q];

    target = relTarget;
    case (pcjumpenable)
      CMD_ABS, CMD_ABS_LINK: target = absTarget;
      CMD_REL, CMD_REL_LINK: target = relTarget;
      default:               target = relTarget;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    instr0_d   = instr0_q;
    instr1_d   = instr1_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    count_d    = count_q;
    inflight_d = inflight_q + 2'(grant) - 2'(retValid);
    drop_d     = drop_q;
    reqPc_d    = reqPc_q;
    reqWr_d    = reqWr_q;
    reqRd_d    = reqRd_q;
    linkEn_d   = redirect & isLink;
    linkData_d = (redirect & isLink) ? (exec_pc[15:0] + 16'd1) : 16'd0;

    if (grant) begin
      reqPc_d[reqWr_q] = fetch_pc_q;
      reqWr_d          = ~reqWr_q;
      fetch_pc_d       = fetch_pc_q + PC_W'(1);
    end
    if (retValid) begin
      reqRd_d = ~reqRd_q;
    end
    if (retValid && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end

    // Slot 0 is the head; slot 1 only ever holds the second-oldest entry.
    case ({pop, retKeep})
      2'b10: begin
        instr0_d = instr1_q;
        pc0_d    = pc1_q;
        count_d  = count_q - 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd0) begin
          instr0_d = imem_rdata;
          pc0_d    = retPc;
        end else begin
          instr1_d = imem_rdata;
          pc1_d    = retPc;
        end
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          instr0_d = imem_rdata;
          pc0_d    = retPc;
        end else begin
          instr0_d = instr1_q;
          pc0_d    = pc1_q;
          instr1_d = imem_rdata;
          pc1_d    = retPc;
        end
      end
      default: ;
    endcase

    // A grant in the redirect cycle is already counted in inflight_d, so it gets dropped too.
    if (redirect) begin
      fetch_pc_d = target;
      count_d    = 2'd0;
      drop_d     = inflight_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= '0;
      instr0_q   <= '0;
      instr1_q   <= '0;
      pc0_q      <= '0;
      pc1_q      <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      reqPc_q[0] <= '0;
      reqPc_q[1] <= '0;
      reqWr_q    <= 1'b0;
      reqRd_q    <= 1'b0;
      linkEn_q   <= 1'b0;
      linkData_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      reqPc_q[0] <= reqPc_d[0];
      reqPc_q[1] <= reqPc_d[1];
      reqWr_q    <= reqWr_d;
      reqRd_q    <= reqRd_d;
      linkEn_q   <= linkEn_d;
      linkData_q <= linkData_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: queue-based reference model with an in-order,
// variable-latency memory, directed scenarios and a randomized phase.
module tb_fetch_pc_unit;
  localparam int PC_W = 20;
  localparam int LINK_REG = 0;

  logic            clock, reset;
  logic [2:0]      pcjumpenable;
  logic [8:0]      pcchange;
  logic [5:0]      pclocation;
  logic [PC_W-1:0] exec_pc;
  logic [5:0]      jump_reg;
  logic [15:0]     jump_reg_data;
  logic [5:0]      link_wr;
  logic [15:0]     link_wr_data;
  logic            link_wr_enable;
  logic [PC_W-1:0] imem_addr;
  logic            imem_req, imem_gnt, imem_rvalid;
  logic [15:0]     imem_rdata, instr;
  logic [PC_W-1:0] instr_pc, previous_programcounter;
  logic            instr_valid, instr_ready;

  fetch_pc_unit #(.PC_W(PC_W), .LINK_REG(LINK_REG)) dut (
    .clock(clock), .reset(reset),
    .pcjumpenable(pcjumpenable), .pcchange(pcchange), .pclocation(pclocation),
    .exec_pc(exec_pc), .jump_reg(jump_reg), .jump_reg_data(jump_reg_data),
    .link_wr(link_wr), .link_wr_data(link_wr_data), .link_wr_enable(link_wr_enable),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .previous_programcounter(previous_programcounter)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct { logic [19:0] pc; bit drop; } infl_t;
  typedef struct { logic [15:0] ins; logic [19:0] pc; } fifo_t;
  typedef struct { logic [19:0] addr; int due; } pend_t;

  infl_t       mInfl[$];
  fifo_t       mFifo[$];
  pend_t       pend[$];
  logic [19:0] mFetchPc = '0;
  bit          mLinkEn = 1'b0;
  logic [15:0] mLinkData = '0;
  int          cycle = 0;
  int          memLatMin = 1, memLatMax = 1;
  bit          memFromQueue = 1'b0;
  int          checkCount = 0, passCount = 0;

  function automatic logic [15:0] memWord(input logic [19:0] a);
    logic [31:0] t;
    t = {12'b0, a} * 32'h0000_9E37 + 32'h0000_5A5A;
    return t[15:0] ^ t[31:16];
  endfunction

  function automatic bit modelReq();
    return !reset && ((mFifo.size() + mInfl.size()) < 2);
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
  endtask

  task automatic checkOutput();
    checkEq("imem_req", imem_req, modelReq());
    checkEq("imem_addr", imem_addr, mFetchPc);
    checkEq("prev_pc", previous_programcounter, mFetchPc);
    checkEq("instr_valid", instr_valid, mFifo.size() > 0);
    if (mFifo.size() > 0) begin
      checkEq("instr", instr, mFifo[0].ins);
      checkEq("instr_pc", instr_pc, mFifo[0].pc);
    end
    checkEq("link_en", link_wr_enable, mLinkEn);
    if (mLinkEn) begin
      checkEq("link_data", link_wr_data, mLinkData);
      checkEq("link_wr", link_wr, LINK_REG);
    end
    checkEq("jump_reg", jump_reg, pclocation);
  endtask

  task automatic modelStep();
    bit grant, ret, pop, redirect;
    infl_t e;
    fifo_t f;
    pend_t p;
    logic [19:0] tgt;
    int off;
    if (reset) begin
      mInfl.delete(); mFifo.delete(); pend.delete();
      mFetchPc = '0; mLinkEn = 1'b0; mLinkData = '0;
      return;
    end
    grant    = imem_gnt && modelReq();
    ret      = imem_rvalid && (mInfl.size() > 0);
    pop      = (mFifo.size() > 0) && instr_ready;
    redirect = (pcjumpenable >= 3'd1) && (pcjumpenable <= 3'd4);
    if (memFromQueue) void'(pend.pop_front());
    if (pop) void'(mFifo.pop_front());
    if (ret) begin
      e = mInfl.pop_front();
      if (!e.drop) begin
        f.ins = imem_rdata; f.pc = e.pc;
        mFifo.push_back(f);
      end
    end
    if (grant) begin
      e.pc = mFetchPc; e.drop = 1'b0;
      mInfl.push_back(e);
      p.addr = mFetchPc; p.due = cycle + $urandom_range(memLatMin, memLatMax);
      pend.push_back(p);
      mFetchPc = mFetchPc + 20'd1;
    end
    if (redirect) begin
      if (pcjumpenable == 3'd1 || pcjumpenable == 3'd4) begin
        off = int'(pcchange);
        if (off >= 256) off = off - 512;
        tgt = 20'(int'(exec_pc) + off);
      end else begin
        tgt = 20'(jump_reg_data);
      end
      foreach (mInfl[i]) mInfl[i].drop = 1'b1;
      mFifo.delete();
      mFetchPc = tgt;
    end
    mLinkEn   = (pcjumpenable == 3'd3) || (pcjumpenable == 3'd4);
    mLinkData = 16'(int'(exec_pc) + 1);
  endtask

  task automatic driveMemory();
    memFromQueue = (pend.size() > 0) && (pend[0].due <= cycle);
    imem_rvalid = memFromQueue;
    if (memFromQueue) imem_rdata = memWord(pend[0].addr);
    else imem_rdata = 16'($urandom);
  endtask

  task automatic runCycle();
    @(negedge clock);
    checkOutput();
    modelStep();
    @(posedge clock);
    #1;
    cycle++;
    driveMemory();
  endtask

  task automatic applyStimulus();
    reset         = ($urandom_range(0, 299) == 0);
    imem_gnt      = ($urandom_range(0, 3) != 0);
    instr_ready   = ($urandom_range(0, 3) != 0);
    pcjumpenable  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    pcchange      = 9'($urandom);
    pclocation    = 6'($urandom);
    exec_pc       = 20'($urandom);
    jump_reg_data = 16'($urandom);
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) runCycle();
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; pcjumpenable = '0; pcchange = '0; pclocation = '0; exec_pc = '0;
    jump_reg_data = '0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b1;

    // Startup with a single-cycle memory.
    doReset(3);
    #2;
    checkEq("startup_req", imem_req, 1);
    checkEq("startup_addr", imem_addr, 0);
    runCycle(); #2;
    checkEq("startup_addr1", imem_addr, 1);
    runCycle(); #2;
    checkEq("first_valid", instr_valid, 1);
    checkEq("first_pc", instr_pc, 0);
    checkEq("first_instr", instr, memWord(20'd0));
    runCycle(); #2;
    checkEq("second_pc", instr_pc, 1);
    for (int i = 0; i < 6; i++) runCycle();

    // Mid-flight reset, a stale return, then backpressure.
    doReset(2);
    instr_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
    for (int i = 0; i < 6; i++) runCycle();
    #2;
    checkEq("bp_req", imem_req, 0);
    checkEq("bp_addr", imem_addr, 2);
    checkEq("bp_valid", instr_valid, 1);
    checkEq("bp_head_pc", instr_pc, 0);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) runCycle();

    // Relative jump backwards.
    pcjumpenable = 3'd1; exec_pc = 20'h00010; pcchange = 9'h1F8;
    runCycle();
    pcjumpenable = 3'd0;
    #2;
    checkEq("rel_addr", imem_addr, 20'h00008);
    checkEq("rel_nolink", link_wr_enable, 0);
    for (int i = 0; i < 4; i++) runCycle();

    // Absolute jump with link.
    pcjumpenable = 3'd3; pclocation = 6'd5; jump_reg_data = 16'h1234; exec_pc = 20'h00040;
    runCycle();
    pcjumpenable = 3'd0;
    #2;
    checkEq("abs_addr", imem_addr, 20'h01234);
    checkEq("abs_link_en", link_wr_enable, 1);
    checkEq("abs_link_wr", link_wr, 0);
    checkEq("abs_link_data", link_wr_data, 16'h0041);
    runCycle(); #2;
    checkEq("abs_link_pulse_end", link_wr_enable, 0);

    // Wrap-around relative jump with link.
    pcjumpenable = 3'd4; exec_pc = 20'hFFFFF; pcchange = 9'd1;
    runCycle();
    pcjumpenable = 3'd0;
    #2;
    checkEq("wrap_addr", imem_addr, 20'h00000);
    checkEq("wrap_link_en", link_wr_enable, 1);
    checkEq("wrap_link_data", link_wr_data, 16'h0000);
    for (int i = 0; i < 4; i++) runCycle();

    // Redirect with two requests outstanding on a 3-cycle memory.
    memLatMin = 3; memLatMax = 3;
    doReset(2);
    runCycle(); runCycle();
    #2;
    checkEq("slow_req_held", imem_req, 0);
    pcjumpenable = 3'd2; jump_reg_data = 16'h0100;
    runCycle();
    pcjumpenable = 3'd0;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      #2;
      if (instr_valid) found = 1'b1;
      else runCycle();
    end
    checkEq("slow_redir_valid", found, 1);
    if (found) checkEq("slow_redir_pc", instr_pc, 20'h00100);

    // Randomized traffic.
    memLatMin = 1; memLatMax = 4;
    for (int n = 0; n < 4000; n++) begin
      applyStimulus();
      runCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
